// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine preset sequencer: phase codes and run-state type.
package wm_pkg;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_WASH  = 2'd1;
   localparam logic [1:0] PH_RINSE = 2'd2;
   localparam logic [1:0] PH_SPIN  = 2'd3;

   // State codes equal the phase codes so the phase output is the state itself.
   typedef enum logic [1:0] {
      ST_IDLE  = PH_IDLE,
      ST_WASH  = PH_WASH,
      ST_RINSE = PH_RINSE,
      ST_SPIN  = PH_SPIN
   } state_t;

endpackage

// File: rtl/wm_preset_bank.sv
// NUM_PRESETS x {wash, rinse, spin, cloth} register array with one write port and a combinational read mux.
module wm_preset_bank
   import wm_pkg::*;
#(
   parameter int NUM_PRESETS = 4,
   parameter int FIELD_W     = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [$clog2(NUM_PRESETS)-1:0] sel,
   input  logic                           wr_en,
   input  logic [FIELD_W-1:0]             wash_in,
   input  logic [FIELD_W-1:0]             rinse_in,
   input  logic [FIELD_W-1:0]             spin_in,
   input  logic [FIELD_W-1:0]             cloth_in,
   output logic [FIELD_W-1:0]             wash_out,
   output logic [FIELD_W-1:0]             rinse_out,
   output logic [FIELD_W-1:0]             spin_out,
   output logic [FIELD_W-1:0]             cloth_out
);

   typedef struct packed {
      logic [FIELD_W-1:0] wash;
      logic [FIELD_W-1:0] rinse;
      logic [FIELD_W-1:0] spin;
      logic [FIELD_W-1:0] cloth;
   } preset_t;

   preset_t mem [NUM_PRESETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_PRESETS; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[sel] <= '{wash: wash_in, rinse: rinse_in, spin: spin_in, cloth: cloth_in};
      end
   end

   assign wash_out  = mem[sel].wash;
   assign rinse_out = mem[sel].rinse;
   assign spin_out  = mem[sel].spin;
   assign cloth_out = mem[sel].cloth;

endmodule

// File: rtl/wm_preset_sequencer.sv
// Preset store plus wash/rinse/spin run controller with prescaled countdown.
// Optional feature: define WM_PAUSE_EN to add the pause input that stalls an active run.
module wm_preset_sequencer
   import wm_pkg::*;
#(
   parameter int NUM_PRESETS = 4,
   parameter int FIELD_W     = 5,
   parameter int PRESCALE    = 1,
   parameter int CLOTH_MAX   = 20
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [$clog2(NUM_PRESETS)-1:0] sel,
   input  logic                           wr_en,
   input  logic [FIELD_W-1:0]             wash_in,
   input  logic [FIELD_W-1:0]             rinse_in,
   input  logic [FIELD_W-1:0]             spin_in,
   input  logic [FIELD_W-1:0]             cloth_in,
   output logic [FIELD_W-1:0]             wash_out,
   output logic [FIELD_W-1:0]             rinse_out,
   output logic [FIELD_W-1:0]             spin_out,
   output logic [FIELD_W-1:0]             cloth_out,
   input  logic                           start,
   input  logic                           abort,
`ifdef WM_PAUSE_EN
   input  logic                           pause,
`endif
   output logic                           busy,
   output logic [1:0]                     phase,
   output logic [FIELD_W-1:0]             remaining,
   output logic                           done,
   output logic                           err
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   // Cloth only gates acceptance, so the run snapshot keeps just the durations.
   typedef struct packed {
      logic [FIELD_W-1:0] wash;
      logic [FIELD_W-1:0] rinse;
      logic [FIELD_W-1:0] spin;
   } run_t;

   run_t               rd, snap_q, snap_d;
   state_t             state_q, state_d, nxt;
   logic [FIELD_W-1:0] rem_q, rem_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic               done_q, done_d, err_q, err_d;
   logic               stall, tick;

   wm_preset_bank #(.NUM_PRESETS(NUM_PRESETS), .FIELD_W(FIELD_W)) u_bank (
      .clk(clk), .rst_n(rst_n), .sel(sel), .wr_en(wr_en),
      .wash_in(wash_in), .rinse_in(rinse_in), .spin_in(spin_in), .cloth_in(cloth_in),
      .wash_out(wash_out), .rinse_out(rinse_out), .spin_out(spin_out), .cloth_out(cloth_out)
   );

   assign rd = '{wash: wash_out, rinse: rinse_out, spin: spin_out};

`ifdef WM_PAUSE_EN
   assign stall = pause;
`else
   assign stall = 1'b0;
`endif

   // First phase after 'cur' with a nonzero duration; ST_IDLE when none is left.
   function automatic state_t next_phase(input state_t cur, input run_t p);
      if (cur == ST_IDLE && p.wash != '0) return ST_WASH;
      if ((cur == ST_IDLE || cur == ST_WASH) && p.rinse != '0) return ST_RINSE;
      if (cur != ST_SPIN && p.spin != '0) return ST_SPIN;
      return ST_IDLE;
   endfunction

   function automatic logic [FIELD_W-1:0] duration(input state_t s, input run_t p);
      case (s)
         ST_WASH:  return p.wash;
         ST_RINSE: return p.rinse;
         ST_SPIN:  return p.spin;
         default:  return '0;
      endcase
   endfunction

   assign tick = (pre_q == PW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         rem_q   <= '0;
         pre_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         rem_q   <= rem_d;
         pre_q   <= pre_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      rem_d   = rem_q;
      pre_d   = pre_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      nxt     = ST_IDLE;
      if (state_q == ST_IDLE) begin
         if (start && !abort) begin
            if (int'(cloth_out) > CLOTH_MAX) begin
               err_d = 1'b1;
            end else begin
               snap_d = rd;
               nxt    = next_phase(ST_IDLE, rd);
               if (nxt == ST_IDLE) begin
                  done_d = 1'b1;
               end else begin
                  state_d = nxt;
                  rem_d   = duration(nxt, rd);
                  pre_d   = '0;
               end
            end
         end
      end else if (abort) begin
         state_d = ST_IDLE;
         rem_d   = '0;
         pre_d   = '0;
      end else if (!stall) begin
         if (tick) begin
            pre_d = '0;
            if (rem_q == FIELD_W'(1)) begin
               nxt     = next_phase(state_q, snap_q);
               state_d = nxt;
               rem_d   = duration(nxt, snap_q);
               done_d  = (nxt == ST_IDLE);
            end else begin
               rem_d = rem_q - FIELD_W'(1);
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign phase     = state_q;
   assign remaining = rem_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_wm_preset_sequencer.sv
// Randomised and directed bench for wm_preset_sequencer; two instances (PRESCALE 1 and 3) share stimulus.
module tb_wm_preset_sequencer;

   localparam int FW = 5;
   localparam int CMAX = 20;
   localparam int PS [2] = '{1, 3};
`ifdef WM_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    sel = '0;
   logic          wr_en = 1'b0, start = 1'b0, abort = 1'b0, pause_v = 1'b0;
   logic [FW-1:0] wash_in = '0, rinse_in = '0, spin_in = '0, cloth_in = '0;

   logic [FW-1:0] wo [2], ro [2], so [2], co [2], rem [2];
   logic          busy [2], done [2], err [2];
   logic [1:0]    phase [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wm_preset_sequencer #(.NUM_PRESETS(4), .FIELD_W(FW), .PRESCALE(PS[g]), .CLOTH_MAX(CMAX)) dut (
         .clk(clk), .rst_n(rst_n), .sel(sel), .wr_en(wr_en),
         .wash_in(wash_in), .rinse_in(rinse_in), .spin_in(spin_in), .cloth_in(cloth_in),
         .wash_out(wo[g]), .rinse_out(ro[g]), .spin_out(so[g]), .cloth_out(co[g]),
         .start(start), .abort(abort),
`ifdef WM_PAUSE_EN
         .pause(pause_v),
`endif
         .busy(busy[g]), .phase(phase[g]), .remaining(rem[g]), .done(done[g]), .err(err[g])
      );
   end

   // Reference: presets as plain arrays; each run is a list of per-cycle (phase, remaining) entries.
   int m_w [4], m_r [4], m_s [4], m_c [4];
   int q [2][$];
   bit e_done [2], e_err [2];
   int bcnt [2];
   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         q[k].delete();
         e_done[k] = 0;
         e_err[k]  = 0;
      end
      for (int i = 0; i < 4; i++) begin
         m_w[i] = 0; m_r[i] = 0; m_s[i] = 0; m_c[i] = 0;
      end
   endtask

   task automatic model_edge();
      int d [3];
      bit was_busy;
      for (int k = 0; k < 2; k++) begin
         was_busy  = (q[k].size() > 0);
         e_done[k] = 0;
         e_err[k]  = 0;
         if (was_busy) begin
            if (abort) q[k].delete();
            else if (!pause_v) begin
               void'(q[k].pop_front());
               if (q[k].size() == 0) e_done[k] = 1;
            end
         end else if (start && !abort) begin
            if (m_c[sel] > CMAX) e_err[k] = 1;
            else begin
               d = '{m_w[sel], m_r[sel], m_s[sel]};
               for (int ph = 1; ph <= 3; ph++)
                  for (int r = d[ph-1]; r >= 1; r--)
                     for (int c = 0; c < PS[k]; c++) q[k].push_back(ph * 256 + r);
               if (q[k].size() == 0) e_done[k] = 1;
            end
         end
      end
      if (wr_en) begin
         m_w[sel] = wash_in; m_r[sel] = rinse_in; m_s[sel] = spin_in; m_c[sel] = cloth_in;
      end
   endtask

   task automatic compare_all();
      int eb, eph, erem;
      for (int k = 0; k < 2; k++) begin
         eb   = (q[k].size() > 0) ? 1 : 0;
         eph  = eb ? q[k][0] / 256 : 0;
         erem = eb ? q[k][0] % 256 : 0;
         chk($sformatf("busy%0d", k), 32'(busy[k]), eb);
         chk($sformatf("phase%0d", k), 32'(phase[k]), eph);
         chk($sformatf("remaining%0d", k), 32'(rem[k]), erem);
         chk($sformatf("done%0d", k), 32'(done[k]), 32'(e_done[k]));
         chk($sformatf("err%0d", k), 32'(err[k]), 32'(e_err[k]));
         chk($sformatf("readback%0d", k), {12'd0, wo[k], ro[k], so[k], co[k]},
             (m_w[sel] << 15) | (m_r[sel] << 10) | (m_s[sel] << 5) | m_c[sel]);
         if (busy[k]) bcnt[k]++;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         compare_all();
      end
   endtask

   task automatic write_preset(input int s, input int w, input int r, input int sp, input int c);
      sel = 2'(s); wash_in = FW'(w); rinse_in = FW'(r); spin_in = FW'(sp); cloth_in = FW'(c);
      wr_en = 1'b1;
      step(1);
      wr_en = 1'b0;
   endtask

   task automatic run(input int s);
      sel = 2'(s);
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      #2;
      model_reset();
      compare_all();
      #10 rst_n = 1'b1;

      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         step(1);
      end
      write_preset(2, 3, 2, 4, 10);
      step(1);

      bcnt = '{0, 0};
      run(2);
      step(30);
      chk("busy_cycles_p1", 32'(bcnt[0]), 32'(3 + 2 + 4));

      write_preset(1, 0, 5, 0, 8);
      run(1);
      step(17);
      write_preset(0, 0, 0, 0, 8);
      run(0);
      step(3);

      write_preset(3, 1, 1, 1, 25);
      run(3);
      step(2);

      run(1);
      step(4);
      chk("abort_at_rem1", 32'(rem[0]), 1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      step(2);
      start = 1'b1; abort = 1'b1;
      step(1);
      start = 1'b0; abort = 1'b0;
      step(2);

      run(2);
      step(6);
      chk("spin_before_reset", 32'(phase[0]), 3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2 rst_n = 1'b1;

      write_preset(0, 2, 0, 0, 1);
      bcnt = '{0, 0};
      run(0);
      step(9);
      chk("busy_cycles_p3", 32'(bcnt[1]), 32'(2 * 3));

      bcnt = '{0, 0};
      run(0);
      step(2);
      pause_v = PAUSE_ON;
      write_preset(0, 7, 7, 7, 1);
      sel = 2'd0;
      step(3);
      pause_v = 1'b0;
      step(10);
      chk("busy_cycles_pause", 32'(bcnt[1]), 32'(6 + (PAUSE_ON ? 4 : 0)));
      step(70);

      for (int i = 0; i < 1500; i++) begin
         sel      = 2'($urandom_range(0, 3));
         wr_en    = ($urandom_range(0, 3) == 0);
         wash_in  = FW'($urandom_range(0, 4));
         rinse_in = FW'($urandom_range(0, 3));
         spin_in  = FW'($urandom_range(0, 4));
         cloth_in = FW'($urandom_range(14, 26));
         start    = ($urandom_range(0, 3) == 0);
         abort    = ($urandom_range(0, 24) == 0);
         pause_v  = PAUSE_ON && ($urandom_range(0, 5) == 0);
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
